// File: rtl/multdiv_ctrl_pkg.sv
// Shared encodings for the multdiv pipeline controller: FSM states,
// exception register/codes and the RUN-phase timeout limit.
package multdiv_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2
  } state_e;

  localparam logic [4:0]  RSTATUS_REG = 5'd30;
  localparam logic [31:0] EXC_MULT    = 32'd4;
  localparam logic [31:0] EXC_DIV     = 32'd5;
  localparam logic [5:0]  TIMEOUT     = 6'd63;

  function automatic logic [31:0] exc_code(input logic is_mult);
    return is_mult ? EXC_MULT : EXC_DIV;
  endfunction

endpackage

// File: rtl/multdiv_ctrl_if.sv
// Signal bundle between the pipeline/multdiv unit (master) and the
// multdiv controller (slave).
interface multdiv_ctrl_if;
  logic        dx_is_mult;
  logic        dx_is_div;
  logic [4:0]  dx_rd;
  logic [31:0] dx_a;
  logic [31:0] dx_b;
  logic        flush;
  logic        md_ready;
  logic        md_exception;
  logic [31:0] md_result;
  logic        wb_grant;
  logic        md_ctrl_mult;
  logic        md_ctrl_div;
  logic [31:0] md_op_a;
  logic [31:0] md_op_b;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        busy;

  modport slave (
    input  dx_is_mult, dx_is_div, dx_rd, dx_a, dx_b, flush,
    input  md_ready, md_exception, md_result, wb_grant,
    output md_ctrl_mult, md_ctrl_div, md_op_a, md_op_b, stall,
    output wb_valid, wb_reg, wb_data, busy
  );

  modport master (
    output dx_is_mult, dx_is_div, dx_rd, dx_a, dx_b, flush,
    output md_ready, md_exception, md_result, wb_grant,
    input  md_ctrl_mult, md_ctrl_div, md_op_a, md_op_b, stall,
    input  wb_valid, wb_reg, wb_data, busy
  );
endinterface

// File: rtl/multdiv_ctrl_md_cycle_counter.sv
// 6-bit RUN-phase cycle counter with synchronous clear and count enable.
module md_cycle_counter (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_clear,
  input  logic       i_en,
  output logic [5:0] o_count
);
  logic [5:0] r_count;

  always_ff @(posedge clock) begin
    if (reset || i_clear) r_count <= 6'd0;
    else if (i_en)        r_count <= r_count + 6'd1;
  end

  assign o_count = r_count;
endmodule

// File: rtl/multdiv_ctrl.sv
// Pipeline-side controller for the multi-cycle mul/div unit: launches the
// op, stalls the front end, and arbitrates the result onto the regfile port.
module multdiv_ctrl
  import multdiv_ctrl_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  multdiv_ctrl_if.slave bus
);
  state_e      r_state, w_next;
  logic [31:0] r_op_a, r_op_b, r_wb_data;
  logic [4:0]  r_rd, r_wb_reg;
  logic        r_is_mult;
  logic [5:0]  w_count;
  logic        w_req, w_accept, w_start, w_ready, w_timeout, w_fail;

  assign w_req     = bus.dx_is_mult | bus.dx_is_div;
  assign w_accept  = (r_state == IDLE) && w_req;
  // Counter is cleared on accept, so zero in RUN marks the start-pulse cycle.
  assign w_start   = (r_state == RUN) && (w_count == 6'd0);
  assign w_ready   = bus.md_ready && !w_start;
  assign w_timeout = (w_count == TIMEOUT) && !bus.md_ready;
  assign w_fail    = (w_ready && bus.md_exception) || w_timeout;

  md_cycle_counter u_cnt (
    .clock   (clock),
    .reset   (reset),
    .i_clear (w_accept),
    .i_en    (r_state == RUN),
    .o_count (w_count)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_req) w_next = RUN;
      RUN: begin
        if (bus.flush)   w_next = IDLE;
        else if (w_fail) w_next = WB;
        else if (w_ready) w_next = (r_rd == 5'd0) ? IDLE : WB;
      end
      WB:      if (bus.wb_grant) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_rd      <= '0;
      r_is_mult <= 1'b0;
      r_wb_reg  <= '0;
      r_wb_data <= '0;
    end else begin
      if (w_accept) begin
        r_op_a    <= bus.dx_a;
        r_op_b    <= bus.dx_b;
        r_rd      <= bus.dx_rd;
        r_is_mult <= bus.dx_is_mult;
      end
      if (r_state == RUN && !bus.flush) begin
        if (w_fail) begin
          r_wb_reg  <= RSTATUS_REG;
          r_wb_data <= exc_code(r_is_mult);
        end else if (w_ready) begin
          r_wb_reg  <= r_rd;
          r_wb_data <= bus.md_result;
        end
      end
    end
  end

  // Outputs are forced low while reset is held, even before the state clears.
  always_comb begin
    bus.md_ctrl_mult = 1'b0;
    bus.md_ctrl_div  = 1'b0;
    bus.md_op_a      = '0;
    bus.md_op_b      = '0;
    bus.stall        = 1'b0;
    bus.wb_valid     = 1'b0;
    bus.wb_reg       = '0;
    bus.wb_data      = '0;
    bus.busy         = 1'b0;
    if (!reset) begin
      bus.md_ctrl_mult = w_start && r_is_mult;
      bus.md_ctrl_div  = w_start && !r_is_mult;
      bus.md_op_a      = r_op_a;
      bus.md_op_b      = r_op_b;
      bus.stall        = w_accept || (r_state == RUN) ||
                         ((r_state == WB) && !bus.wb_grant);
      bus.wb_valid     = (r_state == WB);
      bus.wb_reg       = (r_state == WB) ? r_wb_reg : 5'd0;
      bus.wb_data      = (r_state == WB) ? r_wb_data : 32'd0;
      bus.busy         = (r_state != IDLE);
    end
  end
endmodule
